serializer_10bit: RTL and testbench

SERIALIZER_10BIT -- requirements
Module: serializer_10bit

---
 rtl/serializer_10bit_pkg.sv | 15 +
 rtl/serializer_10bit_if.sv | 14 +
 rtl/serializer_10bit_bit_tick.sv | 29 ++
 rtl/serializer_10bit.sv | 115 +++++++++++
 tb/tb_serializer_10bit.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serializer_10bit_pkg.sv
// Shared widths and FSM encoding for the 10-bit serializer.
package serializer_10bit_pkg;

    localparam int DATA_W     = 10;
    localparam int FRAME_BITS = 12;
    localparam logic [3:0] LAST_BIT_IDX = 4'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/serializer_10bit_if.sv
// Parallel-load / serial-out bundle between the upstream producer and the serializer.
interface serializer_10bit_if;
    import serializer_10bit_pkg::*;

    logic              load;
    logic [DATA_W-1:0] d;
    logic              sout;
    logic              busy;
    logic              done;

    modport master (output load, output d, input sout, input busy, input done);
    modport slave  (input load, input d, output sout, output busy, output done);

endinterface

// File: rtl/serializer_10bit_bit_tick.sv
// Bit-period counter: while enabled, pulses o_tick in the last clk cycle of every DIV-cycle bit.
module bit_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Held at zero while disabled so every frame starts on a fresh bit period.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/serializer_10bit.sv
// 10-bit parallel-to-serial transmitter: start bit, d[0]..d[9] LSB first, stop bit, each held DIV clocks.
module serializer_10bit
    import serializer_10bit_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              clr,
    serializer_10bit_if.slave bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_bitIdx;
    logic              r_sout;
    logic              r_busy;
    logic              r_done;

    state_t            w_stateNext;
    logic [DATA_W-1:0] w_shiftNext;
    logic [3:0]        w_bitIdxNext;
    logic              w_soutNext;
    logic              w_busyNext;
    logic              w_doneNext;
    logic              w_tick;
    logic              w_en;

    assign w_en = (r_state != IDLE);

    bit_tick #(.DIV(DIV)) u_bit_tick (
        .clk    (clk),
        .clr    (clr),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitIdx <= '0;
            r_sout   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_bitIdx <= w_bitIdxNext;
            r_sout   <= w_soutNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
        end
    end

    // Outputs are computed one edge ahead so sout/busy/done come straight from flops.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitIdxNext = r_bitIdx;
        w_soutNext   = r_sout;
        w_busyNext   = r_busy;
        w_doneNext   = 1'b0;

        case (r_state)
            IDLE: begin
                w_soutNext = 1'b1;
                w_busyNext = 1'b0;
                if (bus.load) begin
                    w_stateNext  = START;
                    w_shiftNext  = bus.d;
                    w_bitIdxNext = '0;
                    w_soutNext   = 1'b0;
                    w_busyNext   = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    w_stateNext  = DATA;
                    w_soutNext   = r_shift[0];
                    w_shiftNext  = r_shift >> 1;
                    w_bitIdxNext = '0;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bitIdx == LAST_BIT_IDX) begin
                        w_stateNext  = STOP;
                        w_soutNext   = 1'b1;
                        w_bitIdxNext = '0;
                    end else begin
                        w_bitIdxNext = r_bitIdx + 4'd1;
                        w_soutNext   = r_shift[0];
                        w_shiftNext  = r_shift >> 1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_stateNext = IDLE;
                    w_soutNext  = 1'b1;
                    w_busyNext  = 1'b0;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign bus.sout = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_serializer_10bit.sv
// Randomised self-checking bench for serializer_10bit against a frame-level reference model.
module tb_serializer_10bit;
    import serializer_10bit_pkg::*;

    localparam int DIV = 4;
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic clk;
    logic clr;
    logic chainMode;
    logic [DATA_W-1:0] dManual;
    logic [10:0] freeCnt = '0;
    logic [DATA_W-1:0] upstreamReg = '0;
    logic [DATA_W-1:0] expQ[$];
    int total = 0;
    int bad = 0;

    serializer_10bit_if bus();

    serializer_10bit #(.DIV(DIV)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    assign bus.d = chainMode ? upstreamReg : dManual;

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        freeCnt     <= freeCnt + 11'd1;
        upstreamReg <= freeCnt[9:0];
    end

    // Reference frame: bit position k/DIV of {stop, word, start}.
    function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int k);
        logic [FRAME_BITS-1:0] f;
        f = {1'b1, w, 1'b0};
        return f[k / DIV];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.load = 1'($urandom);
            dManual  = 10'($urandom);
            tick();
            total++;
            if (bus.sout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_hold: got sout=%b busy=%b done=%b, expected 1/0/0",
                         bus.sout, bus.busy, bus.done);
            end
        end
        bus.load = 1'b0;
        clr = 1'b0;
        tick();
        total++;
        if (bus.sout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_release: got sout=%b busy=%b done=%b, expected 1/0/0",
                     bus.sout, bus.busy, bus.done);
        end
    endtask

    task automatic test_single_frame();
        logic [DATA_W-1:0] w;
        w = 10'h2A5;
        dManual = w;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            dManual = 10'($urandom);
            total++;
            if (bus.sout !== exp_bit(w, k) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL single_bit k=%0d: got sout=%b busy=%b done=%b, expected %b/1/0",
                         k, bus.sout, bus.busy, bus.done, exp_bit(w, k));
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.sout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_done: got done=%b busy=%b sout=%b, expected 1/0/1",
                     bus.done, bus.busy, bus.sout);
        end
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_done_width: got done=%b, expected 0", bus.done);
        end
    endtask

    task automatic test_ignored_load();
        logic [DATA_W-1:0] w;
        w = 10'h2A5;
        dManual = w;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k == 10) begin
                bus.load = 1'b1;
                dManual  = 10'h155;
            end else begin
                bus.load = 1'b0;
            end
            total++;
            if (bus.sout !== exp_bit(w, k) || bus.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL ignored_bit k=%0d: got sout=%b busy=%b, expected %b/1",
                         k, bus.sout, bus.busy, exp_bit(w, k));
            end
            tick();
        end
        bus.load = 1'b0;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ignored_done: got done=%b, expected 1", bus.done);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (bus.busy !== 1'b0 || bus.sout !== 1'b1 || bus.done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ignored_no_requeue i=%0d: got busy=%b sout=%b done=%b, expected 0/1/0",
                         i, bus.busy, bus.sout, bus.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] wa;
        logic [DATA_W-1:0] wb;
        int busyCnt;
        int doneCnt;
        wa = 10'($urandom);
        wb = 10'h3FF;
        busyCnt = 0;
        doneCnt = 0;
        dManual = wa;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (bus.busy === 1'b1) busyCnt++;
            total++;
            if (bus.sout !== exp_bit(wa, k)) begin
                bad++;
                $display("[TB] FAIL b2b_first k=%0d: got sout=%b, expected %b", k, bus.sout, exp_bit(wa, k));
            end
            tick();
        end
        if (bus.done === 1'b1) doneCnt++;
        // Load is raised inside the done cycle; the next frame must start on the following edge.
        dManual = wb;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        total++;
        if (bus.sout !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_start: got sout=%b busy=%b, expected 0/1", bus.sout, bus.busy);
        end
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.done === 1'b1) doneCnt++;
            total++;
            if (bus.sout !== exp_bit(wb, k)) begin
                bad++;
                $display("[TB] FAIL b2b_second k=%0d: got sout=%b, expected %b", k, bus.sout, exp_bit(wb, k));
            end
            tick();
        end
        if (bus.done === 1'b1) doneCnt++;
        total++;
        if (busyCnt != 2 * FRAME_CYC) begin
            bad++;
            $display("[TB] FAIL b2b_busy_count: got %0d, expected %0d", busyCnt, 2 * FRAME_CYC);
        end
        total++;
        if (doneCnt != 2) begin
            bad++;
            $display("[TB] FAIL b2b_done_count: got %0d, expected 2", doneCnt);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [DATA_W-1:0] w;
        w = 10'($urandom) & 10'h3DF;
        dManual = w;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k <= 6 * DIV; k++) begin
            total++;
            if (bus.sout !== exp_bit(w, k)) begin
                bad++;
                $display("[TB] FAIL midrst_pre k=%0d: got sout=%b, expected %b", k, bus.sout, exp_bit(w, k));
            end
            tick();
        end
        #20;
        clr = 1'b1;
        #1;
        total++;
        if (bus.sout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_async: got sout=%b busy=%b done=%b, expected 1/0/0",
                     bus.sout, bus.busy, bus.done);
        end
        tick();
        clr = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL midrst_no_done i=%0d: got done=%b busy=%b, expected 0/0",
                         i, bus.done, bus.busy);
            end
        end
        w = 10'h001;
        dManual = w;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            total++;
            if (bus.sout !== exp_bit(w, k) || bus.busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL midrst_after k=%0d: got sout=%b busy=%b, expected %b/1",
                         k, bus.sout, bus.busy, exp_bit(w, k));
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_after_done: got done=%b, expected 1", bus.done);
        end
        tick();
    endtask

    task automatic test_chain();
        logic [DATA_W-1:0] rx;
        logic [DATA_W-1:0] expWord;
        logic prevBusy;
        int framesDone;
        int k;
        int b;
        int cyc;
        rx = '0;
        k = 0;
        framesDone = 0;
        cyc = 0;
        prevBusy = 1'b1;
        chainMode = 1'b1;
        expQ.delete();
        while (framesDone < 6 && cyc < 1000) begin
            if (bus.busy === 1'b1) begin
                if (!prevBusy) k = 0;
                b = k / DIV;
                if ((k % DIV) == DIV / 2 && b >= 1 && b <= DATA_W) rx[b-1] = bus.sout;
                k++;
            end
            if (bus.done === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL chain_spurious_frame: got word %0h, expected none", rx);
                end else begin
                    expWord = expQ.pop_front();
                    if (rx !== expWord) begin
                        bad++;
                        $display("[TB] FAIL chain_word %0d: got %0h, expected %0h", framesDone, rx, expWord);
                    end
                end
                framesDone++;
            end
            if (prevBusy && bus.busy === 1'b0) begin
                bus.load = 1'b1;
                expQ.push_back(upstreamReg);
            end else if (bus.busy === 1'b1 && $urandom_range(0, 5) == 0) begin
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            prevBusy = bus.busy;
            tick();
            cyc++;
        end
        bus.load = 1'b0;
        total++;
        if (framesDone != 6) begin
            bad++;
            $display("[TB] FAIL chain_timeout: got %0d frames, expected 6", framesDone);
        end
        chainMode = 1'b0;
    endtask

    initial begin
        clr       = 1'b1;
        chainMode = 1'b0;
        dManual   = '0;
        bus.load  = 1'b0;
        test_reset();
        test_single_frame();
        test_ignored_load();
        test_back_to_back();
        test_mid_reset();
        test_chain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
